// File: rtl/recovery_scheduler_if.sv
// recovery_scheduler_if
//   Replay beat port between the recovery scheduler and the replay datapath
//   (shift register / register-file copy logic). One beat moves per cycle in
//   which valid and ready are both high.
//
//   Signals:
//     valid  scheduler -> datapath  beat is present
//     ready  datapath  -> scheduler beat accepted this cycle
//     pc     scheduler -> datapath  beat carries the PC rather than a GPR
//     addr   scheduler -> datapath  GPR address of the beat (0 for the PC beat)
//
//   Modports:
//     master  the scheduler side
//     slave   the replay datapath side
interface recovery_scheduler_if #(
    parameter int ADDR_WIDTH = 5
);
    logic                  valid;
    logic                  ready;
    logic                  pc;
    logic [ADDR_WIDTH-1:0] addr;

    modport master (
        output valid,
        output pc,
        output addr,
        input  ready
    );

    modport slave (
        input  valid,
        input  pc,
        input  addr,
        output ready
    );
endinterface

// File: rtl/recovery_scheduler.sv
// recovery_scheduler
//   Shares one register-replay recovery path between NUM_CORES cores. Error
//   reports are latched per core; one core is picked round-robin, halted, its
//   PC and all 2**ADDR_WIDTH GPRs are replayed beat by beat through the replay
//   port, and then it is resumed. A running recovery is never preempted.
//
//   Parameters:
//     NUM_CORES       cores sharing the recovery path (>= 2)
//     ADDR_WIDTH      GPR address width; 2**ADDR_WIDTH registers are replayed
//     TIMEOUT_CYCLES  stall limit per replay beat (timeout build only)
//
//   Ports:
//     clk_i     clock
//     rst_ni    asynchronous active-low reset
//     error_i   per-core error flag, level or pulse
//     halt_o    per-core halt request (one-hot or zero)
//     resume_o  per-core one-cycle resume pulse (one-hot or zero)
//     shift_o   one-cycle checkpoint-shift strobe to the replay datapath
//     replay    replay beat port (master side)
//     owner_o   core currently under recovery
//     busy_o    scheduler is not idle
//     fatal_o   sticky replay-timeout flag
//
//   Build option:
//     RECOVERY_TIMEOUT_EN  when defined, a beat stalled for TIMEOUT_CYCLES
//                          cycles sets fatal_o and ends the recovery early.
//                          When undefined, fatal_o is 0 and stalls are waited
//                          out indefinitely.
module recovery_scheduler #(
    parameter int NUM_CORES      = 3,
    parameter int ADDR_WIDTH     = 5,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NUM_CORES-1:0]         error_i,
    output logic [NUM_CORES-1:0]         halt_o,
    output logic [NUM_CORES-1:0]         resume_o,
    output logic                         shift_o,
    recovery_scheduler_if.master         replay,
    output logic [$clog2(NUM_CORES)-1:0] owner_o,
    output logic                         busy_o,
    output logic                         fatal_o
);

    localparam int OWNER_WIDTH = $clog2(NUM_CORES);
    localparam int NUM_REG     = 2 ** ADDR_WIDTH;

    localparam logic [OWNER_WIDTH-1:0] LAST_CORE = OWNER_WIDTH'(NUM_CORES - 1);
    localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR = ADDR_WIDTH'(NUM_REG - 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] HALT = 3'd1;
    localparam logic [2:0] SPC  = 3'd2;
    localparam logic [2:0] SGPR = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]             state;
    logic [NUM_CORES-1:0]   pending;
    logic [ADDR_WIDTH-1:0]  iterator;
    logic [OWNER_WIDTH-1:0] owner;
    logic [OWNER_WIDTH-1:0] last_grant;

    logic [NUM_CORES-1:0]   request;
    logic                   grant_found;
    logic [OWNER_WIDTH-1:0] grant_idx;
    logic [OWNER_WIDTH-1:0] cand;
    logic [NUM_CORES-1:0]   grant_mask;
    logic [NUM_CORES-1:0]   owner_mask;
    logic                   beat_state;
    logic                   handshake;
    logic                   timeout_hit;

    // A fresh error is visible to arbitration in the same cycle it arrives,
    // giving a one-cycle error-to-halt latency.
    assign request = pending | error_i;

    // Round-robin search starting just above the last core served.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = (last_grant == LAST_CORE) ? '0 : last_grant + OWNER_WIDTH'(1);
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!grant_found && request[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
            cand = (cand == LAST_CORE) ? '0 : cand + OWNER_WIDTH'(1);
        end
    end

    assign grant_mask = (state == IDLE && grant_found)
                        ? (NUM_CORES'(1) << grant_idx) : '0;
    assign owner_mask = NUM_CORES'(1) << owner;

    assign beat_state = (state == SPC) || (state == SGPR);
    assign handshake  = beat_state && replay.ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            pending    <= '0;
            iterator   <= '0;
            owner      <= '0;
            last_grant <= LAST_CORE;
        end else begin
            // The granted bit is consumed. An error on the granted core only
            // survives the grant edge if the bit was already pending, i.e. it
            // is a new report rather than the one being served.
            pending <= (pending & ~grant_mask) | (error_i & ~(grant_mask & ~pending));
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        owner <= grant_idx;
                        state <= HALT;
                    end
                end
                HALT: begin
                    state <= SPC;
                end
                SPC: begin
                    if (timeout_hit) begin
                        state <= DONE;
                    end else if (handshake) begin
                        iterator <= '0;
                        state    <= SGPR;
                    end
                end
                SGPR: begin
                    if (timeout_hit) begin
                        state <= DONE;
                    end else if (handshake) begin
                        if (iterator == LAST_ADDR) begin
                            state <= DONE;
                        end else begin
                            iterator <= iterator + ADDR_WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    last_grant <= owner;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef RECOVERY_TIMEOUT_EN
    localparam int STALL_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [STALL_WIDTH-1:0] stall_count;
    logic                   fatal;

    // Fires on the TIMEOUT_CYCLES-th consecutive stalled cycle of one beat.
    assign timeout_hit = beat_state && !replay.ready
                         && (stall_count == STALL_WIDTH'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_count <= '0;
            fatal       <= 1'b0;
        end else begin
            if (!beat_state || replay.ready) begin
                stall_count <= '0;
            end else if (timeout_hit) begin
                stall_count <= '0;
                fatal       <= 1'b1;
            end else begin
                stall_count <= stall_count + STALL_WIDTH'(1);
            end
        end
    end

    assign fatal_o = fatal;
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign fatal_o        = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    assign halt_o       = (state == HALT || beat_state) ? owner_mask : '0;
    assign resume_o     = (state == DONE) ? owner_mask : '0;
    assign shift_o      = (state == HALT);
    assign replay.valid = beat_state;
    assign replay.pc    = (state == SPC);
    assign replay.addr  = (state == SGPR) ? iterator : '0;
    assign owner_o      = owner;
    assign busy_o       = (state != IDLE);

endmodule

// File: tb/tb_recovery_scheduler.sv
// tb_recovery_scheduler
//   Scoreboard bench for recovery_scheduler. Stimulus pushes the expected
//   event stream (shift strobe, PC beat, GPR beats, resume pulse) per
//   recovery; a monitor pops and compares on every observed event. Timing
//   and reset behaviour are checked directly by the stimulus process.
module tb_recovery_scheduler;

    localparam int NUM_CORES      = 3;
    localparam int ADDR_WIDTH     = 5;
    localparam int NUM_REG        = 32;
    localparam int TIMEOUT_CYCLES = 64;
    localparam int REC_LEN        = 35;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] error = '0;
    logic [2:0] halt;
    logic [2:0] resume;
    logic       shift;
    logic [1:0] owner;
    logic       busy;
    logic       fatal;

    recovery_scheduler_if #(.ADDR_WIDTH(ADDR_WIDTH)) replay_bus ();

    recovery_scheduler #(
        .NUM_CORES     (NUM_CORES),
        .ADDR_WIDTH    (ADDR_WIDTH),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .error_i (error),
        .halt_o  (halt),
        .resume_o(resume),
        .shift_o (shift),
        .replay  (replay_bus),
        .owner_o (owner),
        .busy_o  (busy),
        .fatal_o (fatal)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;   // 0 shift strobe, 1 replay beat, 2 resume pulse
        int core;
        int pc;
        int addr;
    } expect_t;

    expect_t sb[$];
    int checks   = 0;
    int failures = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic pushEntry(input int kind, input int core, input int pc, input int addr);
        expect_t e;
        e.kind = kind;
        e.core = core;
        e.pc   = pc;
        e.addr = addr;
        sb.push_back(e);
    endtask

    task automatic pushRecovery(input int core);
        pushEntry(0, core, 0, 0);
        pushEntry(1, core, 1, 0);
        for (int a = 0; a < NUM_REG; a++) pushEntry(1, core, 0, a);
        pushEntry(2, core, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [2:0] err);
        error = err;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        error = '0;
        replay_bus.ready = 1'b1;
        sb.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    // Counts cycles from the current (HALT) cycle until resume_o is seen.
    task automatic runToResume(output int n, input int budget);
        n = 0;
        while (resume == '0 && n < budget) begin
            tick();
            n++;
        end
        if (resume == '0) begin
            failures++;
            $display("[TB] FAIL resume_wait: no resume within %0d cycles", budget);
        end
    endtask

    // Scoreboard monitor: every shift strobe, accepted beat and resume pulse
    // must match the next queued expectation.
    expect_t    mon_e;
    logic [2:0] mon_mask;
    int         mon_kind;
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("halt_resume_exclusive", {29'd0, halt & resume}, 32'd0);
            if (shift || resume != '0 || (replay_bus.valid && replay_bus.ready)) begin
                mon_kind = shift ? 0 : ((resume != '0) ? 2 : 1);
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL sb_unexpected: event kind %0d, expected none", mon_kind);
                end else begin
                    mon_e    = sb.pop_front();
                    mon_mask = 3'b001 << mon_e.core;
                    checkOutput("sb_kind", mon_kind, mon_e.kind);
                    checkOutput("sb_owner", {30'd0, owner}, mon_e.core);
                    if (mon_e.kind == 2) begin
                        checkOutput("sb_resume", {29'd0, resume}, {29'd0, mon_mask});
                    end else begin
                        checkOutput("sb_halt", {29'd0, halt}, {29'd0, mon_mask});
                    end
                    if (mon_e.kind == 1) begin
                        checkOutput("sb_pc", {31'd0, replay_bus.pc}, mon_e.pc);
                        checkOutput("sb_addr", {27'd0, replay_bus.addr}, mon_e.addr);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        int stall_left;
        int held;
        int release_pending;
        int pulsed;
        replay_bus.ready = 1'b1;

        // Reset state
        #3;
        checkOutput("rst_halt", {29'd0, halt}, 0);
        checkOutput("rst_resume", {29'd0, resume}, 0);
        checkOutput("rst_shift", {31'd0, shift}, 0);
        checkOutput("rst_valid", {31'd0, replay_bus.valid}, 0);
        checkOutput("rst_owner", {30'd0, owner}, 0);
        checkOutput("rst_busy", {31'd0, busy}, 0);
        checkOutput("rst_fatal", {31'd0, fatal}, 0);
        doReset();

        // Single error on core 1
        pushRecovery(1);
        applyStimulus(3'b010);
        tick();
        applyStimulus(3'b000);
        checkOutput("t1_halt", {29'd0, halt}, 3'b010);
        checkOutput("t1_shift", {31'd0, shift}, 1);
        checkOutput("t1_owner", {30'd0, owner}, 1);
        checkOutput("t1_busy", {31'd0, busy}, 1);
        runToResume(n, 100);
        checkOutput("t1_length", n, REC_LEN - 1);
        tick();
        checkOutput("t1_idle", {31'd0, busy}, 0);
        checkOutput("t1_sb_empty", sb.size(), 0);

        // Simultaneous errors on all cores
        doReset();
        pushRecovery(0);
        pushRecovery(1);
        pushRecovery(2);
        applyStimulus(3'b111);
        tick();
        applyStimulus(3'b000);
        for (int k = 0; k < 3; k++) begin
            checkOutput("t2_halt", {29'd0, halt}, 32'd1 << k);
            runToResume(n, 100);
            checkOutput("t2_length", n, REC_LEN - 1);
            tick();
            checkOutput("t2_idle_gap", {31'd0, busy}, 0);
            if (k < 2) tick();
        end
        repeat (5) tick();
        checkOutput("t2_drained", {31'd0, busy}, 0);
        checkOutput("t2_sb_empty", sb.size(), 0);

        // Backpressure at address 7
        doReset();
        pushRecovery(2);
        applyStimulus(3'b100);
        tick();
        applyStimulus(3'b000);
        n = 0;
        stall_left = 5;
        release_pending = 0;
        while (resume == '0 && n < 200) begin
            held = 0;
            if (replay_bus.valid && !replay_bus.pc && replay_bus.addr == 5'd7 && stall_left > 0) begin
                replay_bus.ready = 1'b0;
                stall_left--;
                held = 1;
                if (stall_left == 0) release_pending = 1;
            end else begin
                replay_bus.ready = 1'b1;
            end
            tick();
            n++;
            if (held == 1) begin
                checkOutput("t3_addr_held", {27'd0, replay_bus.addr}, 7);
                checkOutput("t3_valid_held", {31'd0, replay_bus.valid}, 1);
            end else if (release_pending == 1) begin
                checkOutput("t3_addr_next", {27'd0, replay_bus.addr}, 8);
                release_pending = 0;
            end
        end
        replay_bus.ready = 1'b1;
        checkOutput("t3_length", n, REC_LEN - 1 + 5);
        tick();
        checkOutput("t3_sb_empty", sb.size(), 0);

        // Owner re-error during its own recovery
        doReset();
        pushRecovery(0);
        pushRecovery(0);
        applyStimulus(3'b001);
        tick();
        applyStimulus(3'b000);
        n = 0;
        pulsed = 0;
        while (resume == '0 && n < 100) begin
            if (pulsed == 0 && replay_bus.valid && !replay_bus.pc && replay_bus.addr == 5'd12) begin
                applyStimulus(3'b001);
                pulsed = 1;
            end else begin
                applyStimulus(3'b000);
            end
            tick();
            n++;
        end
        applyStimulus(3'b000);
        checkOutput("t4_length", n, REC_LEN - 1);
        checkOutput("t4_resume", {29'd0, resume}, 3'b001);
        tick();
        checkOutput("t4_idle_gap", {31'd0, busy}, 0);
        tick();
        checkOutput("t4_rehalt", {29'd0, halt}, 3'b001);
        runToResume(n, 100);
        checkOutput("t4_length2", n, REC_LEN - 1);
        repeat (4) tick();
        checkOutput("t4_drained", {31'd0, busy}, 0);
        checkOutput("t4_sb_empty", sb.size(), 0);

        // Asynchronous reset in the middle of a recovery
        doReset();
        pushRecovery(1);
        applyStimulus(3'b010);
        tick();
        applyStimulus(3'b000);
        n = 0;
        while (!(replay_bus.valid && !replay_bus.pc && replay_bus.addr == 5'd20) && n < 60) begin
            tick();
            n++;
        end
        checkOutput("t5_reached_20", n, 22);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("t5_halt", {29'd0, halt}, 0);
        checkOutput("t5_valid", {31'd0, replay_bus.valid}, 0);
        checkOutput("t5_addr", {27'd0, replay_bus.addr}, 0);
        checkOutput("t5_busy", {31'd0, busy}, 0);
        checkOutput("t5_resume", {29'd0, resume}, 0);
        checkOutput("t5_owner", {30'd0, owner}, 0);
        sb.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (10) tick();
        checkOutput("t5_stay_idle", {31'd0, busy}, 0);
        checkOutput("t5_no_halt", {29'd0, halt}, 0);

        // Permanent stall at the PC beat
        doReset();
        replay_bus.ready = 1'b0;
        pushEntry(0, 0, 0, 0);
`ifdef RECOVERY_TIMEOUT_EN
        pushEntry(2, 0, 0, 0);
`endif
        applyStimulus(3'b001);
        tick();
        applyStimulus(3'b000);
`ifdef RECOVERY_TIMEOUT_EN
        runToResume(n, 200);
        checkOutput("t6_timeout_len", n, 1 + TIMEOUT_CYCLES);
        checkOutput("t6_fatal", {31'd0, fatal}, 1);
        checkOutput("t6_resume", {29'd0, resume}, 3'b001);
        tick();
        checkOutput("t6_idle", {31'd0, busy}, 0);
        checkOutput("t6_fatal_sticky", {31'd0, fatal}, 1);
`else
        repeat (80) tick();
        checkOutput("t6_busy", {31'd0, busy}, 1);
        checkOutput("t6_valid", {31'd0, replay_bus.valid}, 1);
        checkOutput("t6_pc", {31'd0, replay_bus.pc}, 1);
        checkOutput("t6_halt", {29'd0, halt}, 3'b001);
        checkOutput("t6_fatal", {31'd0, fatal}, 0);
`endif
        checkOutput("t6_sb_empty", sb.size(), 0);
        doReset();
        checkOutput("end_fatal_cleared", {31'd0, fatal}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
